// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// The sub field exists only when NSAC_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NSAC_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef NSAC_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef NSAC_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequenced through one 4-bit ripple slice, one nibble per clock, LSB first.
// Optional feature: define NSAC_SUB_EN to add the sub port (a - b).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               c_r;
    logic               cout_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               accept_s;
    logic [4:0]         slice_s;
    logic [WIDTH-1:0]   b_in_s;
    logic               c_in_s;

    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

    assign bus.in_ready  = (state_r == IDLE) && rst_n;
    assign bus.out_valid = (state_r == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign slice_s       = slice_add(a_r[{cnt_r, 2'b00} +: 4], b_r[{cnt_r, 2'b00} +: 4], c_r);

    // Operand conditioning at accept: subtract is a + ~b + 1.
    always_comb begin
        b_in_s = bus.b;
        c_in_s = bus.cin;
`ifdef NSAC_SUB_EN
        if (bus.sub) begin
            b_in_s = ~bus.b;
            c_in_s = 1'b1;
        end else begin
            b_in_s = bus.b;
            c_in_s = bus.cin;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand latch, slice accumulation and carry chaining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            c_r    <= 1'b0;
            cout_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r   <= bus.a;
                        b_r   <= b_in_s;
                        c_r   <= c_in_s;
                        sum_r <= '0;
                        cnt_r <= '0;
                    end
                end
                RUN: begin
                    sum_r[{cnt_r, 2'b00} +: 4] <= slice_s[3:0];
                    c_r   <= slice_s[4];
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        cout_r <= slice_s[4];
                    end
                end
                DONE: begin
                    sum_r  <= sum_r;
                    cout_r <= cout_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that adds two WIDTH-bit operands through a single 4-bit ripple-carry slice, one nibble per clock, least significant first. A registered carry links consecutive slices. Operands enter and results leave through valid/ready handshakes. Sits in front of the 4-bit ripple adder wherever wide additions are needed but area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 8
- NSLICE (localparam), WIDTH/4, number of slice cycles
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous, active-low reset (sampled on clk rising edge)
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into slice 0
- sub  input  1  subtract request (only present with NSAC_SUB_EN)
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of top slice

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a, b, cin
  - clear sum register
  - slice counter cnt=0
  - carry register c=cin
  - go to RUN
- RUN: each edge computes slice cnt from a[4cnt+3:4cnt] + b[4cnt+3:4cnt] + c.
  - Writes sum[4cnt+3:4cnt]; c ← slice carry.
  - cnt increments.
  - When cnt==NSLICE-1 is processed: cout ← slice carry, go to DONE.
- DONE: out_valid=1. sum and cout are held stable until out_valid&&out_ready, then go to IDLE.
- in_ready = (state==IDLE) && rst_n; combinational from state. in_valid outside IDLE is ignored.
- No back-to-back accept in DONE; the next accept happens in IDLE, earliest one cycle after the output handshake.
- Arithmetic:
  - unsigned modulo 2^WIDTH
  - cout = bit WIDTH of a+b+cin
  - sum bits beyond the current cnt read 0 during RUN (not externally meaningful)
- Reset (rst_n low at a clk edge), from any state including mid-RUN:
  - state=IDLE, cnt=0, c=0
  - sum=0, cout=0, out_valid=0
  - in_ready=0 while rst_n is low
  - a partial operation is discarded, with no output.

## Timing
- The accept edge is E0.
- Slice k is computed at edge E(k+1).
- out_valid is asserted after edge E(NSLICE). It is first visible in the cycle after E(NSLICE); WIDTH=16 gives 4 edges.
- Result latency is NSLICE cycles from accept to out_valid. Throughput is one operation per NSLICE+2 cycles with out_ready held high.
- out_valid falls on the edge where out_ready is sampled high. in_ready rises in the same cycle (IDLE).
- Critical path: one 4-bit ripple plus the carry register; independent of WIDTH.

## Configuration
- Macro NSAC_SUB_EN.
- Defined:
  - The sub port exists and is latched at accept.
  - sub=1 computes a − b: b is inverted at latch and c is initialised to 1 (cin ignored).
  - cout=1 means no borrow (a ≥ b).
  - sub=0 behaves exactly as the undefined case.
- Undefined: the sub port is absent and the block is add-only.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid after 4 edges, sum=0x5555, cout=0; in_ready low for edges E1..E4.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples across all 4 slices). Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Backpressure: out_ready held low 3 cycles after out_valid → sum and cout stable, in_ready=0, a new in_valid is ignored. out_ready=1 → out_valid drops on the next edge and in_ready=1.
- Reset mid-RUN:
  - rst_n low after 2 slices → next cycle out_valid=0, sum=0, in_ready=0.
  - Release, then 0x00FF+0x0001 → sum=0x0100, cout=0.
- Operands change while in RUN (a, b toggled every cycle, in_valid=1) → result equals the sum of the operands latched at E0.
- With NSAC_SUB_EN: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0. With a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
